// File: rtl/acc_drain_serializer_if.sv
// Valid/ready beat stream that carries drained accumulator columns to the writeback path.
interface acc_drain_serializer_if #(
  parameter int ACC_DATA_BITWIDTH = 32,
  parameter int IDX_BITWIDTH      = 2
);
  logic [ACC_DATA_BITWIDTH-1:0] out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [IDX_BITWIDTH-1:0]      out_col_idx;
  logic                         out_last;

  modport master (
    output out_data, out_valid, out_col_idx, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_col_idx, out_last,
    output out_ready
  );
endinterface

// File: rtl/acc_drain_serializer.sv
// Snapshots the accumulator bank on load and streams one column per beat.
// Optional macro ACC_DRAIN_RELU_EN clamps negative words to zero at capture.
module acc_drain_serializer #(
  parameter int ACC_DATA_BITWIDTH = 32,
  parameter int NUM_COLS          = 4,
  parameter int IDX_BITWIDTH      = $clog2(NUM_COLS)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_COLS*ACC_DATA_BITWIDTH-1:0] part_sum_flat,
  input  logic                                  load,
  output logic                                  load_ready,
  output logic                                  load_drop,
  acc_drain_serializer_if.master                out_if
);

  // state | meaning
  // IDLE  | waiting for load; load_ready high, no beat presented
  // SEND  | presenting snap_q[idx_q]; advance on each handshake

  localparam int W = ACC_DATA_BITWIDTH;
  localparam logic [IDX_BITWIDTH-1:0] LAST_IDX = IDX_BITWIDTH'(NUM_COLS - 1);
  localparam logic [IDX_BITWIDTH-1:0] IDX_ONE  = IDX_BITWIDTH'(1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q, state_d;
  logic [W-1:0]            snap_q [NUM_COLS];
  logic [IDX_BITWIDTH-1:0] idx_q, idx_d;
  logic [W-1:0]            data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    ready_q, ready_d;
  logic                    drop_q, drop_d;
  logic                    capture;

  function automatic logic [W-1:0] condition_word(input logic [W-1:0] v);
`ifdef ACC_DRAIN_RELU_EN
    return v[W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    drop_d  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          capture = 1'b1;
          state_d = SEND;
          idx_d   = '0;
          valid_d = 1'b1;
          data_d  = condition_word(part_sum_flat[0 +: W]);
          last_d  = 1'b0;
        end
      end
      SEND: begin
        // busy loads are dropped, including on the final-beat edge
        drop_d = load;
        if (out_if.out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
            data_d  = '0;
            last_d  = 1'b0;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            data_d  = snap_q[idx_q + IDX_ONE];
            last_d  = ((idx_q + IDX_ONE) == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ready_q <= 1'b1;
      drop_q  <= 1'b0;
      for (int k = 0; k < NUM_COLS; k++) snap_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      drop_q  <= drop_d;
      if (capture) begin
        for (int k = 0; k < NUM_COLS; k++)
          snap_q[k] <= condition_word(part_sum_flat[k*W +: W]);
      end
    end
  end

  assign load_ready         = ready_q;
  assign load_drop          = drop_q;
  assign out_if.out_data    = data_q;
  assign out_if.out_valid   = valid_q;
  assign out_if.out_col_idx = idx_q;
  assign out_if.out_last    = last_q;

endmodule
